multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM that sequences a shared-datapath (multi-cycle) MIPS subset core: one ALU, one memory port, IR/MDR/ALUOut holding registers.
- Replaces single-cycle static decode with per-state control strobes.
- Sits between the instruction register (opcode/func), the ALU zero flag, a handshaked memory port and the datapath muxes/write enables.
- ALU function selection within a class stays with the existing ALU decoder; this block supplies only the ALU class.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles spent waiting on mem_ready before the block enters TRAP.
- TO_W, 8, width of the memory-wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from ID onward.
- func  in  6  IR[5:0].
- nop  in  1  IR is all-zero.
- zero  in  1  ALU zero flag; sampled in BR.
- mem_ready  in  1  memory port has completed the current access.
- pc_we  out  1  PC load enable.
- pc_src  out  2  PC source: 00 = PC+4, 01 = ALUOut (branch target), 10 = {PC[31:28], IR[25:0], 00}, 11 = rs value.
- ir_we  out  1  IR load enable.
- mem_rd  out  1  memory read request.
- mem_we  out  1  memory write request.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- reg_we  out  1  register-file write enable.
- dst_sel  out  2  destination register: 00 = rd, 01 = rt, 10 = $31.
- wb_sel  out  2  write-back source: 00 = ALUOut, 01 = MDR, 10 = PC (already PC+4).
- alu_a  out  2  ALU A operand: 00 = PC, 01 = rs, 10 = shamt.
- alu_b  out  2  ALU B operand: 00 = rt, 01 = 4, 10 = ext imm, 11 = ext imm << 2.
- alu_cls  out  2  ALU class: 00 = add, 01 = sub, 10 = funct/opcode decode.
- state  out  4  current state, for debug.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  high while in TRAP.

Behaviour:
- Reset: state = IF, wait counter = 0, all outputs 0.
- Unless a state lists a strobe below, that strobe is 0 (outputs are Moore-decoded from state; alu_a/alu_b/alu_cls are don't-care outside the states that set them).
- IF:
  - mem_rd=1, iord=0, alu_a=00, alu_b=01, alu_cls=00.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=00, next state ID.
  - Without mem_ready: stay in IF and increment the wait counter.
  - If the counter reaches MEM_TIMEOUT: go to TRAP.
- ID:
  - alu_a=00, alu_b=11, alu_cls=00 (ALUOut <= branch target).
  - Dispatch on opcode:
    - 00 with func 08: JR.
    - 00 with func 09: JALR.
    - 00 otherwise: EXR.
    - 23 or 2B: ADR.
    - 04 or 05: BR.
    - 02 or 03: JMP.
    - 08, 0A, 0C, 0D, 0E, 0F: EXI.
    - Any other opcode: TRAP.
- EXR: alu_a = 10 if func is 00 or 02, else 01; alu_b=00; alu_cls=10. Next state WBR.
- WBR: dst_sel=00, wb_sel=00, reg_we = ~nop, retire=1. Next state IF.
- EXI: alu_a=01 (the ALU decoder handles lui), alu_b=10, alu_cls=10. Next state WBI.
- WBI: dst_sel=01, wb_sel=00, reg_we=1, retire=1. Next state IF.
- ADR: alu_a=01, alu_b=10, alu_cls=00. Next state MRD for opcode 23, MWR for opcode 2B.
- MRD:
  - mem_rd=1, iord=1.
  - On mem_ready: next state WBM.
  - The same timeout rule as IF applies.
- WBM: dst_sel=01, wb_sel=01, reg_we=1, retire=1. Next state IF.
- MWR:
  - mem_we=1, iord=1; mem_we is held until mem_ready.
  - On mem_ready: retire=1, next state IF.
  - The same timeout rule as IF applies.
- BR:
  - alu_a=01, alu_b=00, alu_cls=01.
  - pc_we = zero for beq (04), ~zero for bne (05); pc_src=01.
  - retire=1, next state IF.
- JMP:
  - pc_we=1, pc_src=10.
  - For jal (03): reg_we=1, dst_sel=10, wb_sel=10.
  - retire=1, next state IF.
- JR: pc_we=1, pc_src=11, retire=1. Next state IF.
- JALR: pc_we=1, pc_src=11, reg_we=1, dst_sel=00, wb_sel=10, retire=1. Next state IF. rs is read before the write in the same edge.
- TRAP: illegal=1; absorbing; only rst_n leaves it.
- Wait counter: cleared on every state change; saturates at MEM_TIMEOUT.
- rst_n asserted mid-access: state returns to IF immediately and all strobes drop asynchronously; the in-flight memory request is abandoned.
- Latency with zero-wait memory:
  - 3 cycles: BR, JMP, JR, JALR.
  - 4 cycles: R-type, I-type ALU, sw.
  - 5 cycles: lw.

Optional Feature:
- Macro: MCC_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs cyc_cnt and ret_cnt and input cnt_clr.
  - cyc_cnt increments every cycle outside TRAP; ret_cnt increments on retire.
  - Both counters wrap modulo 2^32.
  - cnt_clr zeroes both counters synchronously; clear wins over a simultaneous increment.
  - Both counters reset to 0 on rst_n.
- Undefined: the three ports and both counters are absent.

Decomposition:
- Package mcc_pkg holds:
  - The state encoding: IF=0, ID=1, EXR=2, WBR=3, EXI=4, WBI=5, ADR=6, MRD=7, WBM=8, MWR=9, BR=10, JMP=11, JR=12, JALR=13, TRAP=15.
  - Opcode and func constants.
  - pc_src, alu_a, alu_b, alu_cls, dst_sel and wb_sel encodings.
- Sub-module mcc_wait_timer: the wait counter, with inputs clear, enable and saturation limit, and a timeout output.

Test Plan:
- add, mem_ready tied 1: states IF, ID, EXR, WBR; reg_we=1, dst_sel=00 in WBR; retire at cycle 4.
- lw with mem_ready delayed 3 cycles in MRD: MRD held 4 cycles; WBM has wb_sel=01, dst_sel=01; total 8 cycles.
- beq with zero=0, then zero=1: pc_we=0 in the first BR and pc_we=1, pc_src=01 in the second; retire asserted both times.
- jal, then opcode 3F: JMP has reg_we=1, dst_sel=10, wb_sel=10; opcode 3F goes ID -> TRAP with illegal=1 held for 20 cycles.
- mem_ready held 0 in IF: TRAP entered after exactly 255 wait cycles; rst_n pulsed low mid-MWR drops mem_we asynchronously, and state = IF after release.
- nop (IR all-zero): WBR with reg_we=0 and retire=1; with MCC_PERF_CNT_EN defined, ret_cnt = 1 and cyc_cnt = 4.

Source files
------------

// File: rtl/mcc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state numbering,
// opcode/func constants and the datapath mux select codes.
package mcc_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EXR  = 4'd2,
    S_WBR  = 4'd3,
    S_EXI  = 4'd4,
    S_WBI  = 4'd5,
    S_ADR  = 4'd6,
    S_MRD  = 4'd7,
    S_WBM  = 4'd8,
    S_MWR  = 4'd9,
    S_BR   = 4'd10,
    S_JMP  = 4'd11,
    S_JR   = 4'd12,
    S_JALR = 4'd13,
    S_TRAP = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JTGT   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] ALUA_PC    = 2'b00;
  localparam logic [1:0] ALUA_RS    = 2'b01;
  localparam logic [1:0] ALUA_SHAMT = 2'b10;

  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] CLS_ADD = 2'b00;
  localparam logic [1:0] CLS_SUB = 2'b01;
  localparam logic [1:0] CLS_FN  = 2'b10;

  localparam logic [1:0] DST_RD = 2'b00;
  localparam logic [1:0] DST_RT = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

endpackage

// File: rtl/mcc_wait_timer.sv
// Memory-wait counter: counts stalled cycles, saturates at the limit and
// flags the stalled cycle that would bring the count to the limit.
module mcc_wait_timer
  import mcc_pkg::*;
#(
  parameter int TO_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            timeout
);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [TO_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + {{TO_W{1'b0}}, 1'b1};
  // The stalled cycle whose increment reaches the limit is the last one allowed.
  assign timeout = enable && (cnt_inc >= {1'b0, limit});

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != limit)) begin
      cnt_d = cnt_inc[TO_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for a shared-datapath MIPS subset core. Defining MCC_PERF_CNT_EN
// adds cycle/retire performance counters with a synchronous clear.
module multicycle_ctrl
  import mcc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef MCC_PERF_CNT_EN
  input  logic        cnt_clr,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt,
`endif
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        nop,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        mem_rd,
  output logic        mem_we,
  output logic        iord,
  output logic        reg_we,
  output logic [1:0]  dst_sel,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_a,
  output logic [1:0]  alu_b,
  output logic [1:0]  alu_cls,
  output logic [3:0]  state,
  output logic        retire,
  output logic        illegal
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t state_q, state_d;
  logic   wait_en, timeout, wait_clr;

  assign wait_clr = (state_d != state_q);
  assign state    = state_q;

  mcc_wait_timer #(.TO_W(TO_W)) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wait_clr),
    .enable (wait_en),
    .limit  (TO_LIMIT),
    .timeout(timeout)
  );

  always_comb begin
    state_d = state_q;
    wait_en = 1'b0;
    pc_we   = 1'b0;
    pc_src  = PC_PLUS4;
    ir_we   = 1'b0;
    mem_rd  = 1'b0;
    mem_we  = 1'b0;
    iord    = 1'b0;
    reg_we  = 1'b0;
    dst_sel = DST_RD;
    wb_sel  = WB_ALU;
    alu_a   = ALUA_PC;
    alu_b   = ALUB_RT;
    alu_cls = CLS_ADD;
    retire  = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      S_IF: begin
        mem_rd  = 1'b1;
        alu_b   = ALUB_FOUR;
        wait_en = ~mem_ready;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_ID;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_ID: begin
        alu_b = ALUB_IMM_SH2;
        case (opcode)
          OP_RTYPE: begin
            if (func == FN_JR)        state_d = S_JR;
            else if (func == FN_JALR) state_d = S_JALR;
            else                      state_d = S_EXR;
          end
          OP_LW, OP_SW:   state_d = S_ADR;
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J, OP_JAL:   state_d = S_JMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_EXI;
          default:        state_d = S_TRAP;
        endcase
      end
      S_EXR: begin
        alu_a   = ((func == FN_SLL) || (func == FN_SRL)) ? ALUA_SHAMT : ALUA_RS;
        alu_cls = CLS_FN;
        state_d = S_WBR;
      end
      S_WBR: begin
        reg_we  = ~nop;
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_EXI: begin
        alu_a   = ALUA_RS;
        alu_b   = ALUB_IMM;
        alu_cls = CLS_FN;
        state_d = S_WBI;
      end
      S_WBI: begin
        dst_sel = DST_RT;
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_ADR: begin
        alu_a   = ALUA_RS;
        alu_b   = ALUB_IMM;
        state_d = (opcode == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_rd  = 1'b1;
        iord    = 1'b1;
        wait_en = ~mem_ready;
        if (mem_ready)    state_d = S_WBM;
        else if (timeout) state_d = S_TRAP;
      end
      S_WBM: begin
        dst_sel = DST_RT;
        wb_sel  = WB_MDR;
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_MWR: begin
        mem_we  = 1'b1;
        iord    = 1'b1;
        wait_en = ~mem_ready;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_IF;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_BR: begin
        alu_a   = ALUA_RS;
        alu_cls = CLS_SUB;
        pc_src  = PC_ALUOUT;
        pc_we   = (opcode == OP_BNE) ? ~zero : zero;
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_JMP: begin
        pc_we  = 1'b1;
        pc_src = PC_JTGT;
        if (opcode == OP_JAL) begin
          reg_we  = 1'b1;
          dst_sel = DST_RA;
          wb_sel  = WB_PC;
        end
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_JR: begin
        pc_we   = 1'b1;
        pc_src  = PC_RS;
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_JALR: begin
        pc_we   = 1'b1;
        pc_src  = PC_RS;
        reg_we  = 1'b1;
        wb_sel  = WB_PC;
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_TRAP;
    endcase
    // Strobes fall with rst_n itself so an in-flight access is dropped at once.
    if (!rst_n) begin
      wait_en = 1'b0;
      pc_we   = 1'b0;
      pc_src  = '0;
      ir_we   = 1'b0;
      mem_rd  = 1'b0;
      mem_we  = 1'b0;
      iord    = 1'b0;
      reg_we  = 1'b0;
      dst_sel = '0;
      wb_sel  = '0;
      alu_a   = '0;
      alu_b   = '0;
      alu_cls = '0;
      retire  = 1'b0;
      illegal = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MCC_PERF_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d, ret_cnt_q, ret_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (cnt_clr) begin
      cyc_cnt_d = '0;
      ret_cnt_d = '0;
    end else begin
      if (state_q != S_TRAP) cyc_cnt_d = cyc_cnt_q + 32'd1;
      if (retire)            ret_cnt_d = ret_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level trace model builds the
// expected per-cycle control outputs, compared against the DUT every cycle.
module tb_multicycle_ctrl;

  localparam logic [3:0] ST_IF = 4'd0, ST_ID = 4'd1, ST_EXR = 4'd2, ST_WBR = 4'd3,
                         ST_EXI = 4'd4, ST_WBI = 4'd5, ST_ADR = 4'd6, ST_MRD = 4'd7,
                         ST_WBM = 4'd8, ST_MWR = 4'd9, ST_BR = 4'd10, ST_JMP = 4'd11,
                         ST_JR = 4'd12, ST_JALR = 4'd13, ST_TRAP = 4'd15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0, func = '0;
  logic       nop = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic       pc_we, ir_we, mem_rd, mem_we, iord, reg_we, retire, illegal;
  logic [1:0] pc_src, dst_sel, wb_sel, alu_a, alu_b, alu_cls;
  logic [3:0] state;
`ifdef MCC_PERF_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MCC_PERF_CNT_EN
    .cnt_clr(cnt_clr), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
`endif
    .opcode(opcode), .func(func), .nop(nop), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_rd(mem_rd), .mem_we(mem_we),
    .iord(iord), .reg_we(reg_we), .dst_sel(dst_sel), .wb_sel(wb_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cls(alu_cls), .state(state),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op, fn;
    logic       nopi, z, rdy;
    logic [3:0] st;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we, mem_rd, mem_we, iord, reg_we;
    logic [1:0] dst, wb;
    logic       ret, ill;
    logic       alu_care;
    logic [1:0] a, b, c;
  } cyc_t;

  cyc_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   last_ret, first_ill;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic cyc_t mk(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn,
                              input logic nopi, input logic z);
    cyc_t c;
    c = '{default: '0};
    c.st = st; c.op = op; c.fn = fn; c.nopi = nopi; c.z = z; c.rdy = 1'b1;
    return c;
  endfunction

  function automatic cyc_t with_alu(input cyc_t c, input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] cls);
    c.alu_care = 1'b1; c.a = a; c.b = b; c.c = cls;
    return c;
  endfunction

  // Instruction classes: 0 R-type ALU, 1 jr, 2 jalr, 3 I-type ALU, 4 lw, 5 sw, 6 branch, 7 jump, 8 illegal
  function automatic int iclass(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return (fn == 6'h08) ? 1 : (fn == 6'h09) ? 2 : 0;
    if (op == 6'h23) return 4;
    if (op == 6'h2B) return 5;
    if (op == 6'h04 || op == 6'h05) return 6;
    if (op == 6'h02 || op == 6'h03) return 7;
    if (op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D || op == 6'h0E || op == 6'h0F)
      return 3;
    return 8;
  endfunction

  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic nopi,
                           input logic z, input int if_wait, input int mem_wait);
    cyc_t c;
    for (int i = 0; i <= if_wait; i++) begin
      c = with_alu(mk(ST_IF, op, fn, nopi, z), 2'd0, 2'd1, 2'd0);
      c.rdy = (i == if_wait); c.mem_rd = 1'b1; c.ir_we = c.rdy; c.pc_we = c.rdy;
      exp_q.push_back(c);
    end
    exp_q.push_back(with_alu(mk(ST_ID, op, fn, nopi, z), 2'd0, 2'd3, 2'd0));
    case (iclass(op, fn))
      0: begin
        exp_q.push_back(with_alu(mk(ST_EXR, op, fn, nopi, z),
                                 (fn == 6'h00 || fn == 6'h02) ? 2'd2 : 2'd1, 2'd0, 2'd2));
        c = mk(ST_WBR, op, fn, nopi, z); c.reg_we = ~nopi; c.ret = 1'b1;
        exp_q.push_back(c);
      end
      1: begin
        c = mk(ST_JR, op, fn, nopi, z); c.pc_we = 1'b1; c.pc_src = 2'd3; c.ret = 1'b1;
        exp_q.push_back(c);
      end
      2: begin
        c = mk(ST_JALR, op, fn, nopi, z); c.pc_we = 1'b1; c.pc_src = 2'd3; c.reg_we = 1'b1;
        c.wb = 2'd2; c.ret = 1'b1;
        exp_q.push_back(c);
      end
      3: begin
        exp_q.push_back(with_alu(mk(ST_EXI, op, fn, nopi, z), 2'd1, 2'd2, 2'd2));
        c = mk(ST_WBI, op, fn, nopi, z); c.dst = 2'd1; c.reg_we = 1'b1; c.ret = 1'b1;
        exp_q.push_back(c);
      end
      4, 5: begin
        exp_q.push_back(with_alu(mk(ST_ADR, op, fn, nopi, z), 2'd1, 2'd2, 2'd0));
        for (int i = 0; i <= mem_wait; i++) begin
          c = mk((op == 6'h23) ? ST_MRD : ST_MWR, op, fn, nopi, z);
          c.rdy = (i == mem_wait); c.iord = 1'b1;
          if (op == 6'h23) c.mem_rd = 1'b1;
          else begin c.mem_we = 1'b1; c.ret = c.rdy; end
          exp_q.push_back(c);
        end
        if (op == 6'h23) begin
          c = mk(ST_WBM, op, fn, nopi, z); c.dst = 2'd1; c.wb = 2'd1; c.reg_we = 1'b1;
          c.ret = 1'b1;
          exp_q.push_back(c);
        end
      end
      6: begin
        c = with_alu(mk(ST_BR, op, fn, nopi, z), 2'd1, 2'd0, 2'd1);
        c.pc_src = 2'd1; c.pc_we = (op == 6'h04) ? z : ~z; c.ret = 1'b1;
        exp_q.push_back(c);
      end
      7: begin
        c = mk(ST_JMP, op, fn, nopi, z); c.pc_we = 1'b1; c.pc_src = 2'd2; c.ret = 1'b1;
        if (op == 6'h03) begin c.reg_we = 1'b1; c.dst = 2'd2; c.wb = 2'd2; end
        exp_q.push_back(c);
      end
      default: begin
        for (int i = 0; i < 20; i++) begin
          c = mk(ST_TRAP, op, fn, nopi, z); c.ill = 1'b1; c.rdy = i[0];
          exp_q.push_back(c);
        end
      end
    endcase
  endtask

  function automatic logic [31:0] ctl_now();
    return 32'({state, pc_we, pc_src, ir_we, mem_rd, mem_we, iord, reg_we, dst_sel, wb_sel,
                retire, illegal});
  endfunction

  // Drives each expected cycle's inputs on the falling edge and checks 1ns later.
  task automatic run_q();
    cyc_t c;
    int   idx = 0;
    last_ret = 0; first_ill = 0;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      @(negedge clk);
      opcode = c.op; func = c.fn; nop = c.nopi; zero = c.z; mem_ready = c.rdy;
      #1;
      idx++;
      chk($sformatf("ctl_c%0d_st%0d", idx, c.st), ctl_now(),
          32'({c.st, c.pc_we, c.pc_src, c.ir_we, c.mem_rd, c.mem_we, c.iord, c.reg_we,
               c.dst, c.wb, c.ret, c.ill}));
      if (c.alu_care)
        chk($sformatf("alu_c%0d_st%0d", idx, c.st), 32'({alu_a, alu_b, alu_cls}),
            32'({c.a, c.b, c.c}));
      if (retire === 1'b1) last_ret = idx;
      if (illegal === 1'b1 && first_ill == 0) first_ill = idx;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: every output held at 0.
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", ctl_now(), 32'd0);
    chk("reset_alu", 32'({alu_a, alu_b, alu_cls}), 32'd0);
    release_reset();

    // nop: sll $0,$0,0
    add_instr(6'h00, 6'h00, 1'b1, 1'b0, 0, 0);
    chk("nop_len", exp_q.size(), 4);
    run_q();
    chk("nop_retire_cyc", last_ret, 4);
`ifdef MCC_PERF_CNT_EN
    @(posedge clk); #1;
    chk("nop_ret_cnt", ret_cnt, 32'd1);
    chk("nop_cyc_cnt", cyc_cnt, 32'd4);
`endif

    add_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, 0);   // add
    chk("add_len", exp_q.size(), 4);
    run_q();
    chk("add_retire_cyc", last_ret, 4);

    add_instr(6'h23, 6'h00, 1'b0, 1'b0, 0, 3);   // lw, 3-cycle memory stall
    chk("lw_len", exp_q.size(), 8);
    run_q();
    chk("lw_retire_cyc", last_ret, 8);

    add_instr(6'h04, 6'h00, 1'b0, 1'b0, 0, 0);   // beq not taken
    add_instr(6'h04, 6'h00, 1'b0, 1'b1, 0, 0);   // beq taken
    chk("beq_pair_len", exp_q.size(), 6);
    run_q();
    chk("beq_retire_cyc", last_ret, 6);

    add_instr(6'h05, 6'h00, 1'b0, 1'b1, 2, 0);   // bne not taken, fetch stalled 2
    add_instr(6'h2B, 6'h00, 1'b0, 1'b0, 0, 0);   // sw
    add_instr(6'h2B, 6'h00, 1'b0, 1'b0, 0, 2);   // sw, stalled
    add_instr(6'h02, 6'h00, 1'b0, 1'b0, 0, 0);   // j
    add_instr(6'h03, 6'h00, 1'b0, 1'b0, 0, 0);   // jal
    add_instr(6'h00, 6'h08, 1'b0, 1'b0, 0, 0);   // jr
    add_instr(6'h00, 6'h09, 1'b0, 1'b0, 0, 0);   // jalr
    add_instr(6'h00, 6'h02, 1'b0, 1'b0, 0, 0);   // srl
    add_instr(6'h08, 6'h00, 1'b0, 1'b0, 0, 0);   // addi
    add_instr(6'h0F, 6'h00, 1'b0, 1'b0, 0, 0);   // lui
    run_q();

    add_instr(6'h3F, 6'h00, 1'b0, 1'b0, 0, 0);   // undefined opcode
    chk("trap_len", exp_q.size(), 22);
    run_q();
    chk("trap_first_cyc", first_ill, 3);
`ifdef MCC_PERF_CNT_EN
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_cyc_cnt", cyc_cnt, 32'd0);
    chk("clr_ret_cnt", ret_cnt, 32'd0);
`endif

    // Fetch that never completes: TRAP after 255 stalled IF cycles.
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("trap_reset_ctl", ctl_now(), 32'd0);
    release_reset();
    for (int i = 0; i < 255; i++) begin
      cyc_t c;
      c = with_alu(mk(ST_IF, 6'h00, 6'h20, 1'b0, 1'b0), 2'd0, 2'd1, 2'd0);
      c.rdy = 1'b0; c.mem_rd = 1'b1;
      exp_q.push_back(c);
    end
    for (int i = 0; i < 3; i++) begin
      cyc_t c;
      c = mk(ST_TRAP, 6'h00, 6'h20, 1'b0, 1'b0); c.ill = 1'b1;
      exp_q.push_back(c);
    end
    run_q();
    chk("timeout_first_trap_cyc", first_ill, 256);

    // Reset pulled while a store is stalled in MWR.
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("mwr_pre_reset_ctl", ctl_now(), 32'd0);
    release_reset();
    add_instr(6'h2B, 6'h00, 1'b0, 1'b0, 0, 3);
    void'(exp_q.pop_back());
    run_q();
    chk("mwr_before_abort", 32'({state, mem_we}), 32'({ST_MWR, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("mwr_abort_mem_we", 32'(mem_we), 32'd0);
    chk("mwr_abort_ctl", ctl_now(), 32'd0);
    release_reset();
    #1 chk("mwr_release_state", 32'({state, mem_rd}), 32'({ST_IF, 1'b1}));
    add_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, 0);
    run_q();
    chk("post_abort_retire_cyc", last_ret, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
